// File: rtl/dot_seq_pkg.sv
// Shared state encoding and width helpers for the dot-product sequencer.
package dot_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    FEED    = 3'd2,
    DRAIN   = 3'd3,
    CAPTURE = 3'd4,
    RESULT  = 3'd5
  } dot_state_e;

  // Accumulator width: wide enough for 2**dw products of two dw-bit operands.
  function automatic int acc_w(input int dw);
    return 3 * dw;
  endfunction

  // Element counter must be able to hold the full vector length itself.
  function automatic int cnt_w(input int vec_len);
    return $clog2(vec_len + 1);
  endfunction

endpackage

// File: rtl/dot_seq_if.sv
// Operand stream, MAC drive and result handshake of the dot-product sequencer.
interface dot_seq_if
  import dot_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 8
);
  localparam int ACC_W = acc_w(DATA_WIDTH);

  logic                  start;
  logic                  busy;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_a;
  logic [DATA_WIDTH-1:0] in_b;
  logic                  mac_clr;
  logic                  mac_en;
  logic [DATA_WIDTH-1:0] mac_a;
  logic [DATA_WIDTH-1:0] mac_b;
  logic [ACC_W-1:0]      mac_cout;
  logic                  res_valid;
  logic                  res_ready;
  logic [ACC_W-1:0]      res_data;

  // Sequencer side.
  modport master (
    input  start, in_valid, in_a, in_b, mac_cout, res_ready,
    output busy, in_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data
  );

  // Environment side: operand source, MAC and result consumer.
  modport slave (
    output start, in_valid, in_a, in_b, mac_cout, res_ready,
    input  busy, in_ready, mac_clr, mac_en, mac_a, mac_b, res_valid, res_data
  );

endinterface

// File: rtl/dot_seq.sv
// Dot-product sequencer: clears the MAC, streams operand pairs into it, captures Cout.
// Optional DOT_SEQ_RUNTIME_LEN_EN adds a cfg_len port for a per-run vector length.
module dot_seq
  import dot_seq_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int VEC_LEN    = 8,
  localparam int CNT_W      = cnt_w(VEC_LEN)
) (
  input  logic             clk,
  input  logic             rst,
`ifdef DOT_SEQ_RUNTIME_LEN_EN
  input  logic [CNT_W-1:0] cfg_len,
`endif
  dot_seq_if.master        bus
);

  localparam int ACC_W = acc_w(DATA_WIDTH);

  localparam logic [2:0] S_IDLE    = 3'(IDLE);
  localparam logic [2:0] S_CLEAR   = 3'(CLEAR);
  localparam logic [2:0] S_FEED    = 3'(FEED);
  localparam logic [2:0] S_DRAIN   = 3'(DRAIN);
  localparam logic [2:0] S_CAPTURE = 3'(CAPTURE);
  localparam logic [2:0] S_RESULT  = 3'(RESULT);

  logic [2:0]            state_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic                  mac_clr_reg;
  logic                  mac_en_reg;
  logic [DATA_WIDTH-1:0] mac_a_reg;
  logic [DATA_WIDTH-1:0] mac_b_reg;
  logic                  res_valid_reg;
  logic [ACC_W-1:0]      res_data_reg;

  logic [CNT_W-1:0]      last_idx;
  logic                  skip_feed;
  logic                  feed_hs;

`ifdef DOT_SEQ_RUNTIME_LEN_EN
  logic [CNT_W-1:0]      len_reg;

  // Length is latched with the accepted start and clamped to what the datapath was sized for.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_reg <= '0;
    end else if (state_reg == S_IDLE && bus.start) begin
      len_reg <= (cfg_len > CNT_W'(VEC_LEN)) ? CNT_W'(VEC_LEN) : cfg_len;
    end
  end

  assign last_idx  = len_reg - CNT_W'(1);
  assign skip_feed = (len_reg == '0);
`else
  assign last_idx  = CNT_W'(VEC_LEN - 1);
  assign skip_feed = 1'b0;
`endif

  assign feed_hs = bus.in_valid && (state_reg == S_FEED);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_IDLE;
      cnt_reg       <= '0;
      mac_clr_reg   <= 1'b0;
      mac_en_reg    <= 1'b0;
      mac_a_reg     <= '0;
      mac_b_reg     <= '0;
      res_valid_reg <= 1'b0;
      res_data_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (bus.start) begin
            mac_clr_reg <= 1'b1;
            state_reg   <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          mac_clr_reg <= 1'b0;
          cnt_reg     <= '0;
          // A zero-length run has nothing to feed; the freshly cleared MAC already reads 0.
          state_reg   <= skip_feed ? S_CAPTURE : S_FEED;
        end
        S_FEED: begin
          if (feed_hs) begin
            mac_a_reg  <= bus.in_a;
            mac_b_reg  <= bus.in_b;
            mac_en_reg <= 1'b1;
            cnt_reg    <= cnt_reg + CNT_W'(1);
            if (cnt_reg == last_idx) begin
              state_reg <= S_DRAIN;
            end
          end else begin
            mac_en_reg <= 1'b0;
          end
        end
        S_DRAIN: begin
          // The last pair is on the MAC inputs this cycle; Cout settles one edge later.
          mac_en_reg <= 1'b0;
          state_reg  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          res_data_reg  <= bus.mac_cout;
          res_valid_reg <= 1'b1;
          state_reg     <= S_RESULT;
        end
        S_RESULT: begin
          if (bus.res_ready) begin
            res_valid_reg <= 1'b0;
            state_reg     <= S_IDLE;
          end
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = (state_reg != S_IDLE);
  assign bus.in_ready  = (state_reg == S_FEED);
  assign bus.mac_clr   = mac_clr_reg;
  assign bus.mac_en    = mac_en_reg;
  assign bus.mac_a     = mac_a_reg;
  assign bus.mac_b     = mac_b_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;

endmodule
